// File: rtl/control_cmd_drawrect_pkg.sv
// Shared types and sizing for the draw-rectangle command decoder.
// Holds address types, rectangle mode, FSM states and small helpers.
package control_cmd_drawrect_pkg;

  localparam int unsigned ColAddrWidth   = 8;
  localparam int unsigned RowAddrWidth   = 8;
  localparam int unsigned PixelAddrWidth = 2;

  localparam int unsigned DefBytesPerPixel = 2;
  localparam int unsigned DefPanelWidth    = 64;
  localparam int unsigned DefPanelHeight   = 32;

  typedef logic [ColAddrWidth-1:0]   col_addr_t;
  typedef logic [RowAddrWidth-1:0]   row_addr_t;
  typedef logic [PixelAddrWidth-1:0] pixel_addr_t;

  // One guard bit so start + length cannot wrap.
  typedef logic [ColAddrWidth:0] col_ext_t;
  typedef logic [RowAddrWidth:0] row_ext_t;

  typedef enum logic {
    RectSolid   = 1'b0,
    RectOutline = 1'b1
  } rect_mode_t;

  typedef enum logic [3:0] {
    StX1, StY1, StW, StH, StMode, StColor, StSetup, StStart, StWrite, StDone
  } state_t;

  function automatic int unsigned num_bytes_to_contain(input int unsigned bits);
    return (bits + 7) / 8;
  endfunction

  localparam int unsigned Ncb          = num_bytes_to_contain(ColAddrWidth);
  localparam int unsigned ColByteWidth = Ncb * 8;

  function automatic logic [7:0] color_byte(input logic [31:0] color, input pixel_addr_t idx);
    return 8'(color >> {idx, 3'b000});
  endfunction

endpackage

// File: rtl/control_cmd_drawrect_if.sv
// Command byte stream in, frame-buffer write port out.
interface control_cmd_drawrect_if;
  import control_cmd_drawrect_pkg::*;

  logic [7:0]  data_in;
  logic        enable;
  row_addr_t   row;
  col_addr_t   column;
  pixel_addr_t pixel;
  logic [7:0]  data_out;
  logic        ram_write_enable;
  logic        ram_access_start;
  logic        ready_for_data;
  logic        done;

  modport master (
    output data_in, enable,
    input  row, column, pixel, data_out, ram_write_enable, ram_access_start, ready_for_data, done
  );

  modport slave (
    input  data_in, enable,
    output row, column, pixel, data_out, ram_write_enable, ram_access_start, ready_for_data, done
  );

endinterface

// File: rtl/control_cmd_drawrect_scan.sv
// Row-major scan over a clipped rectangle, solid or one-pixel outline.
// Emits the current row/column/pixel-byte and flags the final byte.
module control_cmd_drawrect_scan
  import control_cmd_drawrect_pkg::*;
#(
  parameter int unsigned BYTES_PER_PIXEL = DefBytesPerPixel
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  col_addr_t   x1,
  input  col_addr_t   x_end,
  input  col_ext_t    x_last,
  input  row_addr_t   y1,
  input  row_addr_t   y_end,
  input  row_ext_t    y_last,
  input  rect_mode_t  mode,
  output row_addr_t   row,
  output col_addr_t   column,
  output pixel_addr_t pixel,
  output logic        last
);

  localparam pixel_addr_t PixTop = pixel_addr_t'(BYTES_PER_PIXEL - 1);

  logic      full_row;
  logic      right_drawn;
  col_addr_t row_last_col;

  always_comb begin
    right_drawn = x_last <= {1'b0, x_end};
    full_row    = (mode == RectSolid) || (row == y1) || ({1'b0, row} == y_last);
    // Outline side rows visit only x1 and, if not clipped, x_last.
    if (full_row) begin
      row_last_col = x_end;
    end else if (right_drawn) begin
      row_last_col = col_addr_t'(x_last);
    end else begin
      row_last_col = x1;
    end
    last = (pixel == '0) && (row == y_end) && (column == row_last_col);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row    <= '0;
      column <= '0;
      pixel  <= '0;
    end else if (load) begin
      row    <= y1;
      column <= x1;
      pixel  <= PixTop;
    end else if (advance && !last) begin
      if (pixel != '0) begin
        pixel <= pixel - pixel_addr_t'(1);
      end else begin
        pixel <= PixTop;
        if (column != row_last_col) begin
          column <= full_row ? column + col_addr_t'(1) : row_last_col;
        end else begin
          column <= x1;
          row    <= row + row_addr_t'(1);
        end
      end
    end
  end

endmodule

// File: rtl/control_cmd_drawrect.sv
// Draw-rectangle command: captures x1/y1/width/height/mode/colour bytes,
// clips to the panel and writes the frame buffer one byte per cycle.
module control_cmd_drawrect
  import control_cmd_drawrect_pkg::*;
#(
  parameter int unsigned BYTES_PER_PIXEL = DefBytesPerPixel,
  parameter int unsigned PANEL_WIDTH     = DefPanelWidth,
  parameter int unsigned PANEL_HEIGHT    = DefPanelHeight
) (
  input logic                  clk,
  input logic                  reset,
  control_cmd_drawrect_if.slave bus
);

  localparam int unsigned ColorWidth = BYTES_PER_PIXEL * 8;
  localparam pixel_addr_t PixTop     = pixel_addr_t'(BYTES_PER_PIXEL - 1);

  state_t                  state_q;
  logic [1:0]              byte_cnt_q;
  logic [ColByteWidth-1:0] x1_raw_q;
  logic [ColByteWidth-1:0] width_raw_q;
  row_addr_t               y1_q;
  row_addr_t               height_q;
  rect_mode_t              mode_q;
  logic [ColorWidth-1:0]   color_q;
  col_ext_t                x_last_q;
  row_ext_t                y_last_q;
  col_addr_t               x_end_q;
  row_addr_t               y_end_q;
  logic [7:0]              data_out_q;
  logic                    wr_en_q;
  logic                    start_q;
  logic                    done_q;
  logic                    ready_q;

  col_addr_t   x1;
  col_addr_t   width;
  col_ext_t    x_last_c;
  row_ext_t    y_last_c;
  col_addr_t   x_end_c;
  row_addr_t   y_end_c;
  logic        empty_c;
  logic [31:0] color32;

  row_addr_t   scan_row;
  col_addr_t   scan_col;
  pixel_addr_t scan_pix;
  logic        scan_last;

  always_comb begin
    x1       = col_addr_t'(x1_raw_q);
    width    = col_addr_t'(width_raw_q);
    x_last_c = {1'b0, x1} + {1'b0, width} - col_ext_t'(1);
    y_last_c = {1'b0, y1_q} + {1'b0, height_q} - row_ext_t'(1);
    x_end_c  = (x_last_c > col_ext_t'(PANEL_WIDTH - 1)) ? col_addr_t'(PANEL_WIDTH - 1)
                                                         : col_addr_t'(x_last_c);
    y_end_c  = (y_last_c > row_ext_t'(PANEL_HEIGHT - 1)) ? row_addr_t'(PANEL_HEIGHT - 1)
                                                          : row_addr_t'(y_last_c);
    empty_c  = (width == '0) || (height_q == '0) ||
               ({1'b0, x1} >= col_ext_t'(PANEL_WIDTH)) ||
               ({1'b0, y1_q} >= row_ext_t'(PANEL_HEIGHT));
    color32  = 32'(color_q);
  end

  control_cmd_drawrect_scan #(
    .BYTES_PER_PIXEL(BYTES_PER_PIXEL)
  ) u_scan (
    .clk    (clk),
    .reset  (reset),
    .load   (state_q == StStart),
    .advance(state_q == StWrite),
    .x1     (x1),
    .x_end  (x_end_q),
    .x_last (x_last_q),
    .y1     (y1_q),
    .y_end  (y_end_q),
    .y_last (y_last_q),
    .mode   (mode_q),
    .row    (scan_row),
    .column (scan_col),
    .pixel  (scan_pix),
    .last   (scan_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StX1;
      byte_cnt_q  <= '0;
      x1_raw_q    <= '0;
      width_raw_q <= '0;
      y1_q        <= '0;
      height_q    <= '0;
      mode_q      <= RectSolid;
      color_q     <= '0;
      x_last_q    <= '0;
      y_last_q    <= '0;
      x_end_q     <= '0;
      y_end_q     <= '0;
      data_out_q  <= '0;
      wr_en_q     <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        StX1: if (bus.enable) begin
          x1_raw_q <= (x1_raw_q << 8) | ColByteWidth'(bus.data_in);
          if (byte_cnt_q == 2'(Ncb - 1)) begin
            byte_cnt_q <= '0;
            state_q    <= StY1;
          end else begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        StY1: if (bus.enable) begin
          y1_q    <= bus.data_in;
          state_q <= StW;
        end
        StW: if (bus.enable) begin
          width_raw_q <= (width_raw_q << 8) | ColByteWidth'(bus.data_in);
          if (byte_cnt_q == 2'(Ncb - 1)) begin
            byte_cnt_q <= '0;
            state_q    <= StH;
          end else begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        StH: if (bus.enable) begin
          height_q <= bus.data_in;
          state_q  <= StMode;
        end
        StMode: if (bus.enable) begin
          mode_q  <= rect_mode_t'(bus.data_in[0]);
          state_q <= StColor;
        end
        StColor: if (bus.enable) begin
          color_q <= (color_q << 8) | ColorWidth'(bus.data_in);
          if (byte_cnt_q == 2'(BYTES_PER_PIXEL - 1)) begin
            byte_cnt_q <= '0;
            ready_q    <= 1'b0;
            state_q    <= StSetup;
          end else begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        StSetup: begin
          x_last_q <= x_last_c;
          y_last_q <= y_last_c;
          x_end_q  <= x_end_c;
          y_end_q  <= y_end_c;
          if (empty_c) begin
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= StDone;
          end else begin
            start_q <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          wr_en_q    <= 1'b1;
          data_out_q <= color_byte(color32, PixTop);
          state_q    <= StWrite;
        end
        StWrite: begin
          if (scan_last) begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= StDone;
          end else begin
            // Byte for the scan position the generator moves to this edge.
            data_out_q <= color_byte(color32, (scan_pix == '0) ? PixTop
                                                               : scan_pix - pixel_addr_t'(1));
          end
        end
        StDone: begin
          width_raw_q <= '0;
          y1_q        <= '0;
          height_q    <= '0;
          mode_q      <= RectSolid;
          color_q     <= '0;
          byte_cnt_q  <= '0;
          data_out_q  <= '0;
          // ready_for_data is high here, so a byte now is the first x1 byte.
          x1_raw_q <= bus.enable ? ColByteWidth'(bus.data_in) : '0;
          state_q  <= StX1;
          if (bus.enable) begin
            if (Ncb == 1) begin
              state_q <= StY1;
            end else begin
              byte_cnt_q <= 2'd1;
            end
          end
        end
        default: state_q <= StX1;
      endcase
    end
  end

  always_comb begin
    bus.row              = scan_row;
    bus.column           = scan_col;
    bus.pixel            = scan_pix;
    bus.data_out         = data_out_q;
    bus.ram_write_enable = wr_en_q;
    bus.ram_access_start = start_q;
    bus.ready_for_data   = ready_q;
    bus.done             = done_q;
  end

endmodule

// File: tb/tb_control_cmd_drawrect.sv
// Directed bench for control_cmd_drawrect on a 64x32 panel, 2 bytes per pixel.
module tb_control_cmd_drawrect;
  import control_cmd_drawrect_pkg::*;

  localparam int unsigned Bpp    = 2;
  localparam int unsigned PanelW = 64;
  localparam int unsigned PanelH = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  control_cmd_drawrect_if bus ();

  control_cmd_drawrect #(
    .BYTES_PER_PIXEL(Bpp),
    .PANEL_WIDTH    (PanelW),
    .PANEL_HEIGHT   (PanelH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] wq[$];
  int          wt[$];
  int          starts, dones, start_t, done_t, last_t;

  always @(negedge clk) begin
    if (bus.ram_write_enable) begin
      wq.push_back({bus.row, bus.column, 6'd0, bus.pixel, bus.data_out});
      wt.push_back(cyc);
    end
    if (bus.ram_access_start) begin
      starts++;
      start_t = cyc;
    end
    if (bus.done) begin
      dones++;
      done_t = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wr_word(input int r, input int c, input int p, input int d);
    return {8'(r), 8'(c), 8'(p), 8'(d)};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bus.data_in = b;
    bus.enable  = 1'b1;
    last_t      = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int x1, input int y1, input int w, input int h,
                          input logic [7:0] mode, input logic [15:0] color);
    wq.delete();
    wt.delete();
    starts  = 0;
    dones   = 0;
    start_t = -1;
    done_t  = -1;
    send_byte(8'(x1));
    send_byte(8'(y1));
    send_byte(8'(w));
    send_byte(8'(h));
    send_byte(mode);
    send_byte(color[15:8]);
    send_byte(color[7:0]);
    bus.enable  = 1'b0;
    bus.data_in = 8'h00;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (dones == 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_done_seen"}, 32'(dones != 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Expected pixel: high colour byte at pixel=1 then low byte at pixel=0.
  task automatic check_px(input string tag, inout int idx, input int r, input int c,
                          input logic [15:0] color);
    for (int p = 1; p >= 0; p--) begin
      check($sformatf("%s_w%0d", tag, idx), (idx < wq.size()) ? wq[idx] : 32'hDEADDEAD,
            wr_word(r, c, p, (p == 1) ? int'(color[15:8]) : int'(color[7:0])));
      idx++;
    end
  endtask

  task automatic check_timing(input string tag, input int nwr);
    int last;
    check({tag, "_nwr"}, 32'(wq.size()), 32'(nwr));
    check({tag, "_starts"}, 32'(starts), 32'd1);
    check({tag, "_dones"}, 32'(dones), 32'd1);
    check({tag, "_start_t"}, 32'(start_t), 32'(last_t + 2));
    if (wt.size() > 0) begin
      last = wt.size() - 1;
      check({tag, "_first_wr_t"}, 32'(wt[0]), 32'(last_t + 3));
      check({tag, "_contig"}, 32'(wt[last] - wt[0]), 32'(nwr - 1));
      check({tag, "_done_t"}, 32'(done_t), 32'(wt[last] + 1));
    end
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_nwr"}, 32'(wq.size()), 32'd0);
    check({tag, "_starts"}, 32'(starts), 32'd0);
    check({tag, "_done_t"}, 32'(done_t), 32'(last_t + 2));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_row"}, 32'(bus.row), 32'd0);
    check({tag, "_col"}, 32'(bus.column), 32'd0);
    check({tag, "_pix"}, 32'(bus.pixel), 32'd0);
    check({tag, "_data"}, 32'(bus.data_out), 32'd0);
    check({tag, "_wren"}, 32'(bus.ram_write_enable), 32'd0);
    check({tag, "_start"}, 32'(bus.ram_access_start), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_ready"}, 32'(bus.ready_for_data), 32'd1);
  endtask

  initial begin
    int idx;
    int n;
    bus.enable  = 1'b0;
    bus.data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("post_rst");

    // Solid 3x2 at (2,3).
    send_cmd(2, 3, 3, 2, 8'h00, 16'hABCD);
    wait_done("solid");
    check_timing("solid", 12);
    idx = 0;
    for (int r = 3; r <= 4; r++)
      for (int c = 2; c <= 4; c++) check_px("solid", idx, r, c, 16'hABCD);

    // Outline 4x4 at origin: rows 0/3 full, rows 1/2 only cols 0 and 3.
    send_cmd(0, 0, 4, 4, 8'h01, 16'h1234);
    wait_done("outl");
    check_timing("outl", 24);
    idx = 0;
    for (int r = 0; r <= 3; r++) begin
      if (r == 0 || r == 3) begin
        for (int c = 0; c <= 3; c++) check_px("outl", idx, r, c, 16'h1234);
      end else begin
        check_px("outl", idx, r, 0, 16'h1234);
        check_px("outl", idx, r, 3, 16'h1234);
      end
    end

    // Clipped solid: only cols 62-63, rows 30-31 survive.
    send_cmd(62, 30, 10, 10, 8'h00, 16'h55AA);
    wait_done("clip_s");
    check_timing("clip_s", 8);
    idx = 0;
    for (int r = 30; r <= 31; r++)
      for (int c = 62; c <= 63; c++) check_px("clip_s", idx, r, c, 16'h55AA);

    // Clipped outline: top edge and left edge only.
    send_cmd(62, 30, 10, 10, 8'h01, 16'h9966);
    wait_done("clip_o");
    check_timing("clip_o", 6);
    idx = 0;
    check_px("clip_o", idx, 30, 62, 16'h9966);
    check_px("clip_o", idx, 30, 63, 16'h9966);
    check_px("clip_o", idx, 31, 62, 16'h9966);

    send_cmd(5, 5, 0, 3, 8'h00, 16'h1111);
    wait_done("empty_w");
    check_empty("empty_w");

    send_cmd(70, 2, 4, 4, 8'h00, 16'h2222);
    wait_done("empty_x");
    check_empty("empty_x");

    // Mode bits[7:1] set, bit0 clear: still a 1x1 solid.
    send_cmd(10, 10, 1, 1, 8'hFE, 16'h7E81);
    wait_done("mode_hi");
    check_timing("mode_hi", 2);
    idx = 0;
    check_px("mode_hi", idx, 10, 10, 16'h7E81);

    // Garbage bytes while writing must be ignored.
    send_cmd(1, 1, 5, 5, 8'h00, 16'h2468);
    n = 0;
    while (wq.size() == 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("garb_wr_seen", 32'(wq.size() != 0), 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus.data_in = 8'(8'hF0 + i);
      bus.enable  = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.enable  = 1'b0;
    bus.data_in = 8'h00;
    wait_done("garb");
    check("garb_nwr", 32'(wq.size()), 32'd50);
    send_cmd(3, 4, 1, 1, 8'h00, 16'hBEEF);
    wait_done("after_garb");
    check_timing("after_garb", 2);
    idx = 0;
    check_px("after_garb", idx, 4, 3, 16'hBEEF);

    // Reset mid-write, then a fresh 2x1 outline command.
    send_cmd(0, 0, 20, 10, 8'h00, 16'h1111);
    n = 0;
    while (wq.size() == 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rstw_wr_seen", 32'(wq.size() != 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_idle_outputs("rstw");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_cmd(10, 20, 2, 1, 8'h01, 16'h1357);
    wait_done("post_rstw");
    check_timing("post_rstw", 4);
    idx = 0;
    check_px("post_rstw", idx, 20, 10, 16'h1357);
    check_px("post_rstw", idx, 20, 11, 16'h1357);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/control_cmd_drawrect.md
# control_cmd_drawrect

Parametrised successor to the fill-rectangle command decoder for the LED panel's frame-buffer control path. Captures a rectangle command from the UART byte stream, including a mode byte that selects solid fill or one-pixel outline, clips it to the panel, then writes the frame-buffer RAM byte-by-byte itself. It runs on a single clock, needs no fill sub-command and no done-pulse synchroniser, and sits beside the other `control_cmd_*` blocks under the command dispatcher.

## Interface
- BYTES_PER_PIXEL, params::BYTES_PER_PIXEL, colour bytes per pixel (1..4)
- PANEL_WIDTH, params::PIXEL_WIDTH, visible columns; clip bound
- PANEL_HEIGHT, params::PIXEL_HEIGHT, visible rows; clip bound
- clk  in  1  sole clock (command and RAM side)
- reset  in  1  asynchronous, active-high
- data_in  in  8  command byte
- enable  in  1  data_in valid; consumed only while ready_for_data=1
- row  out  types::row_addr_t  write row
- column  out  types::col_addr_t  write column
- pixel  out  types::pixel_addr_t  byte index within pixel
- data_out  out  8  colour byte being written
- ram_write_enable  out  1  write strobe, one byte per cycle
- ram_access_start  out  1  one-cycle pulse before the first write
- ready_for_data  out  1  block accepts command bytes
- done  out  1  one-cycle completion pulse

## Operation
- Byte order: x1 (NCB = calc::num_bytes_to_contain($bits(col_addr_t)) bytes, MSB first), y1 (1), width (NCB, MSB first), height (1), mode (1), colour (BYTES_PER_PIXEL, MSB first).
- Mode byte: bit0=1 outline, bit0=0 solid fill. Bits[7:1] are ignored.
- States: X1, Y1, W, H, MODE, COLOR (capture), SETUP, START, WRITE, DONE.
- On the last colour byte: ready_for_data←0 and go to SETUP.
- SETUP computes, with one guard bit so the sum cannot wrap:
  - x_last = x1+width-1 and y_last = y1+height-1 (unclipped)
  - x_end = min(x_last, PANEL_WIDTH-1) and y_end = min(y_last, PANEL_HEIGHT-1)
- Empty command: width=0, height=0, x1≥PANEL_WIDTH or y1≥PANEL_HEIGHT. SETUP goes straight to DONE with no ram_access_start and no writes.
- Otherwise START pulses ram_access_start, then WRITE runs.
- WRITE scans row-major: row y1..y_end, column x1..x_end.
  - Per pixel: pixel counts BYTES_PER_PIXEL-1 down to 0; data_out = colour[(pixel+1)*8-1 -: 8].
- Outline mode:
  - Rows y1 and y_last are drawn in full.
  - Other rows write only column x1, plus column x_last if x_last≤x_end. The scan jumps directly between those two columns.
  - An edge that is clipped away is not drawn. Do not substitute x_end or y_end for it.
- After the final byte, go to DONE: done=1 and ready_for_data=1 for one cycle. Capture registers and counters are re-initialised, then the block returns to X1.
- enable while ready_for_data=0 is ignored; no byte is buffered.

## Timing
- Reset values: row=0, column=0, pixel=0, data_out=0, ram_write_enable=0, ram_access_start=0, done=0, ready_for_data=1. The FSM is in X1.
- Reset mid-command or mid-write: all outputs take their reset values immediately, and the partial command is discarded.
- Capture: one byte per cycle with enable high; no stall.
- Latency:
  - Last colour byte at cycle N: SETUP at N+1, ram_access_start at N+2, first ram_write_enable at N+3.
  - Empty command: done at N+2.
- row, column, pixel and data_out are registered, and are valid exactly while ram_write_enable=1.
- Write counts:
  - Solid: (x_end-x1+1)·(y_end-y1+1)·BYTES_PER_PIXEL consecutive write cycles, no bubbles.
  - Outline: one write per drawn pixel byte, no bubbles.
- done is asserted the cycle after the last write.

## Structure
- Shared package `types`: add `rect_mode_t` (enum: SOLID=0, OUTLINE=1) and a `col_ext_t` (col_addr_t width + 1) for the guard-bit arithmetic.
- `calc` package: NCB and counter widths, as for the other `control_cmd_*` blocks.
- One sub-module is natural: `rect_scan_gen`. It takes the bounds and mode, and emits row/column/pixel/last.
- The capture FSM stays in this module.

## Test plan
- Panel 64×32, BPP=2, solid; bytes x1=2, y1=3, w=3, h=2, colour 0xABCD -> 12 writes covering (r3,c2..4) then (r4,c2..4). Each pixel writes pixel=1→0xAB, then pixel=0→0xCD. Exactly one ram_access_start and one done.
- Outline x1=0, y1=0, w=4, h=4 -> rows 0 and 3 full; rows 1–2 cols 0 and 3 only; 12 pixels, 24 write cycles, contiguous.
- Clip: x1=62, y1=30, w=10, h=10 solid -> writes cols 62–63, rows 30–31 only (8 writes). Outline of the same rectangle -> no right or bottom edge drawn.
- Empty: w=0, or x1=70 -> no ram_write_enable and no ram_access_start; done 2 cycles after the last byte.
- Reset asserted mid-WRITE -> outputs at reset values in the same cycle. A new command afterwards executes correctly.
- Enable pulses during WRITE with garbage bytes -> ignored. The following command is decoded correctly.
